// File: rtl/io_led_ctrl.sv
// io_led_ctrl: register-mapped LED controller at $DEF8-$DEFF (static/blink/chase/PWM + latched error LED).
// Build option: define LED_PWM_EN to implement PWM mode 3 and the DUTY register.
module io_led_ctrl #(
   parameter int TICK_DIV = 27000,
   parameter int ERR_HALF = 128
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bus_access_strobe,
   input  logic [15:0] a,
   input  logic        ext_io_en,
   input  logic        r_w_n,
   input  logic [7:0]  d_in,
   output logic [7:0]  d_out,
   input  logic        err_in,
   output logic [4:0]  leds,
   output logic        led_err
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int EW = (ERR_HALF > 2) ? $clog2(ERR_HALF) : 1;
   localparam logic [12:0] PAGE = 13'h1BDF;   // $DEF8 >> 3

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_CHASE  = 2'd2,
      MODE_PWM    = 2'd3
   } mode_e;

   logic [7:0]    ctrl, rate, step_cnt, duty_rd;
   logic [4:0]    data, leds_nxt;
   logic [PW-1:0] pre_cnt;
   logic [EW-1:0] err_cnt;
   logic          hit, wr, wr_ctrl, wr_rate, wr_stat, wr_data;
   logic          tick, step, restart, phase, err_latched, err_ph, pwm_on;
   mode_e         mode;

   assign hit     = (a[15:3] == PAGE);
   assign wr      = ext_io_en && bus_access_strobe && hit && !r_w_n;
   assign wr_ctrl = wr && (a[2:0] == 3'd0);
   assign wr_rate = wr && (a[2:0] == 3'd1);
   assign wr_stat = wr && (a[2:0] == 3'd3);
   assign wr_data = wr && (a[2:0] == 3'd7);
   assign mode    = mode_e'(ctrl[1:0]);

   // Any of these realigns the step sequence so a new setting starts on the on phase.
   assign restart = wr_rate || wr_data || (wr_ctrl && (d_in[1:0] != ctrl[1:0]));
   assign tick    = (pre_cnt == PW'(TICK_DIV - 1));
   assign step    = tick && (step_cnt == rate) && !restart;

`ifdef LED_PWM_EN
   logic [7:0] duty, pwm_cnt;
   logic       wr_duty;
   assign wr_duty = wr && (a[2:0] == 3'd2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty    <= 8'h80;
         pwm_cnt <= 8'h00;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (wr_duty) duty <= d_in;
      end
   end
   assign duty_rd = duty;
   assign pwm_on  = (pwm_cnt < duty);
`else
   assign duty_rd = 8'h00;
   assign pwm_on  = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl <= 8'h80;
         rate <= 8'h00;
         data <= 5'h1F;
      end else begin
         if (wr_ctrl) ctrl <= d_in;
         if (wr_rate) rate <= d_in;
         // A CPU write beats a coincident chase rotation.
         if (wr_data)
            data <= d_in[4:0];
         else if (step && (mode == MODE_CHASE))
            data <= {data[3:0], data[4]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step_cnt <= 8'h00;
         phase    <= 1'b0;
      end else if (restart) begin
         step_cnt <= 8'h00;
         phase    <= 1'b0;
      end else if (tick) begin
         step_cnt <= step ? 8'h00 : step_cnt + 8'd1;
         if (step && (mode == MODE_BLINK)) phase <= ~phase;
      end
   end

   // Set beats clear; a fresh set restarts the blink so the LED comes on first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_latched <= 1'b0;
         err_cnt     <= '0;
         err_ph      <= 1'b0;
      end else begin
         if (err_in)                  err_latched <= 1'b1;
         else if (wr_stat && d_in[0]) err_latched <= 1'b0;

         if (err_in && !err_latched) begin
            err_cnt <= '0;
            err_ph  <= 1'b0;
         end else if (err_latched && tick) begin
            if (err_cnt == EW'(ERR_HALF - 1)) begin
               err_cnt <= '0;
               err_ph  <= ~err_ph;
            end else begin
               err_cnt <= err_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      leds_nxt = 5'h1F;
      if (ctrl[7]) begin
         case (mode)
            MODE_BLINK: leds_nxt = phase ? 5'h1F : data;
            MODE_PWM:   leds_nxt = pwm_on ? data : 5'h1F;
            default:    leds_nxt = data;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         leds    <= 5'h1F;
         led_err <= 1'b1;
      end else begin
         leds    <= leds_nxt;
         led_err <= err_latched ? err_ph : 1'b1;
      end
   end

   always_comb begin
      d_out = 8'h00;
      if (hit) begin
         case (a[2:0])
            3'd0:    d_out = ctrl;
            3'd1:    d_out = rate;
            3'd2:    d_out = duty_rd;
            3'd3:    d_out = {6'b0, phase, err_latched};
            3'd7:    d_out = {3'b000, data};
            default: d_out = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_io_led_ctrl.sv
// Bench for io_led_ctrl: directed + randomized steps checked against a time-based model
// (LED state derived from edge counts since reset/restart rather than by cycle simulation).
module tb_io_led_ctrl;
   localparam int TD = 4;
   localparam int EH = 2;
   localparam logic [15:0] A_CTRL = 16'hDEF8, A_RATE = 16'hDEF9, A_DUTY = 16'hDEFA,
                           A_STAT = 16'hDEFB, A_DATA = 16'hDEFF;

   logic        clk, reset_n, bus_access_strobe, ext_io_en, r_w_n, err_in, led_err;
   logic [15:0] a;
   logic [7:0]  d_in, d_out;
   logic [4:0]  leds;

   io_led_ctrl #(.TICK_DIV(TD), .ERR_HALF(EH)) dut (
      .clk(clk), .reset_n(reset_n), .bus_access_strobe(bus_access_strobe), .a(a),
      .ext_io_en(ext_io_en), .r_w_n(r_w_n), .d_in(d_in), .d_out(d_out),
      .err_in(err_in), .leds(leds), .led_err(led_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge index since reset release: ticks land on edges that are multiples of TD.
   int cyc;
   always @(posedge clk or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;

   // Model: current settings plus the edge of the last step restart / error set.
   int         m_en, m_mode, m_rate, m_duty, m_r, m_es;
   logic [4:0] m_dw;
   logic       m_err;

   function automatic int ticks(int f, int t);
      return t / TD - f / TD;
   endfunction

   function automatic logic [4:0] rotl(logic [4:0] v, int n);
      logic [4:0] r = v;
      for (int i = 0; i < n % 5; i++) r = {r[3:0], r[4]};
      return r;
   endfunction

   function automatic logic [4:0] m_data(int e);
      if (m_mode == 2) return rotl(m_dw, ticks(m_r, e) / (m_rate + 1));
      return m_dw;
   endfunction

   function automatic logic m_phase(int e);
      if (m_mode == 1) return ((ticks(m_r, e) / (m_rate + 1)) % 2) == 1;
      return 1'b0;
   endfunction

   // Outputs seen after edge e reflect the state after edge e-1.
   function automatic logic [7:0] exp_leds(int e);
      int s = e - 1;
      logic [4:0] d = m_data(s);
      if (m_en == 0) return 8'h1F;
      if (m_mode == 1 && m_phase(s)) return 8'h1F;
`ifdef LED_PWM_EN
      if (m_mode == 3 && (s % 256) >= m_duty) return 8'h1F;
`endif
      return {3'b000, d};
   endfunction

   function automatic logic [7:0] exp_lerr(int e);
      int s = e - 1;
      if (m_err && s >= m_es) return {7'b0, ((ticks(m_es, s) / EH) % 2) == 1};
      return 8'h01;
   endfunction

   function automatic logic [7:0] exp_status(int e);
      return {6'b0, m_phase(e), m_err};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic cyc_step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [15:0] addr, input logic [7:0] d, input logic ext,
                         input logic e_in, output int ed);
      a = addr; d_in = d; r_w_n = 1'b0; ext_io_en = ext; bus_access_strobe = 1'b1; err_in = e_in;
      @(posedge clk);
      #1;
      ed = cyc;
      bus_access_strobe = 1'b0; ext_io_en = 1'b0; r_w_n = 1'b1; err_in = 1'b0;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [7:0] d, output int ed);
      bus_wr(addr, d, 1'b1, 1'b0, ed);
   endtask

   task automatic rd(input logic [15:0] addr, output logic [7:0] v);
      a = addr; r_w_n = 1'b1; ext_io_en = 1'b1; bus_access_strobe = 1'b1;
      #1;
      v = d_out;
      bus_access_strobe = 1'b0; ext_io_en = 1'b0;
   endtask

   task automatic run_chk(input int n, input string tag);
      repeat (n) begin
         cyc_step();
         chk({tag, "_leds"}, {3'b000, leds}, exp_leds(cyc));
         chk({tag, "_lerr"}, {7'b0, led_err}, exp_lerr(cyc));
      end
   endtask

   initial begin
      int ed, lit;
      logic [7:0] v, rv, dv;

      reset_n = 1'b0; bus_access_strobe = 1'b0; ext_io_en = 1'b0; r_w_n = 1'b1;
      err_in = 1'b0; a = 16'h0000; d_in = 8'h00;
      m_en = 1; m_mode = 0; m_rate = 0; m_duty = 128; m_r = 0; m_es = 0;
      m_dw = 5'h1F; m_err = 1'b0;

      // Reset state
      #12;
      chk("rst_leds", {3'b000, leds}, 8'h1F);
      chk("rst_lerr", {7'b0, led_err}, 8'h01);
      rd(A_DATA, v); chk("rst_data", v, 8'h1F);
      rd(A_CTRL, v); chk("rst_ctrl", v, 8'h80);
      rd(A_STAT, v); chk("rst_stat", v, 8'h00);
      @(negedge clk); reset_n = 1'b1;
      cyc_step();
`ifdef LED_PWM_EN
      rd(A_DUTY, v); chk("rst_duty", v, 8'h80);
`else
      rd(A_DUTY, v); chk("rst_duty", v, 8'h00);
`endif
      rd(A_RATE, v); chk("rst_rate", v, 8'h00);
      run_chk(6, "rst");
      rd(A_STAT, v); chk("rst_stat2", v, exp_status(cyc));

      // Static: one-cycle output latency
      wr(A_DATA, 8'h15, ed); m_dw = 5'h15; m_r = ed;
      chk("st_lat", {3'b000, leds}, 8'h1F);
      run_chk(1, "st");
      chk("st_val", {3'b000, leds}, 8'h15);
      rd(A_DATA, v); chk("st_rb", v, 8'h15);
      repeat (4) begin
         dv = 8'($urandom_range(0, 255));
         wr(A_DATA, dv, ed); m_dw = dv[4:0]; m_r = ed;
         run_chk(3, "st_rand");
         rd(A_DATA, v); chk("st_rand_rb", v, {3'b000, m_dw});
      end
      wr(16'hDEFC, 8'h00, ed);
      bus_wr(A_DATA, 8'h00, 1'b0, 1'b0, ed);
      rd(A_DATA, v); chk("unmapped_wr", v, {3'b000, m_dw});
      rd(16'hDEFD, v); chk("unmapped_rd", v, 8'h00);
      run_chk(3, "st_keep");

      // Blink
      wr(A_CTRL, 8'h81, ed); m_mode = 1; m_r = ed;
      wr(A_RATE, 8'h01, ed); m_rate = 1; m_r = ed;
      wr(A_DATA, 8'h00, ed); m_dw = 5'h00; m_r = ed;
      run_chk(40, "blink");
      rd(A_STAT, v); chk("blink_stat", v, exp_status(cyc));
      repeat ($urandom_range(1, 6)) cyc_step();
      wr(A_RATE, 8'h01, ed); m_r = ed;
      run_chk(20, "blink_rate_restart");
      wr(A_CTRL, 8'h81, ed);
      run_chk(12, "blink_same_mode");
      wr(A_CTRL, 8'h01, ed); m_en = 0;
      run_chk(10, "blink_dis");
      wr(A_CTRL, 8'h81, ed); m_en = 1;
      run_chk(10, "blink_reen");
      rd(A_CTRL, v); chk("ctrl_rb", v, 8'h81);
      repeat (3) begin
         rv = 8'($urandom_range(0, 3));
         dv = 8'($urandom_range(0, 31));
         wr(A_RATE, rv, ed); m_rate = int'(rv); m_r = ed;
         wr(A_DATA, dv, ed); m_dw = dv[4:0]; m_r = ed;
         run_chk(30, "blink_rand");
         rd(A_STAT, v); chk("blink_rand_stat", v, exp_status(cyc));
      end

      // Chase
      wr(A_CTRL, 8'h82, ed); m_mode = 2; m_r = ed;
      wr(A_RATE, 8'h00, ed); m_rate = 0; m_r = ed;
      wr(A_DATA, 8'h1E, ed); m_dw = 5'h1E; m_r = ed;
      run_chk(24, "chase");
      rd(A_DATA, v); chk("chase_rb", v, {3'b000, m_data(cyc)});
      while (((cyc + 1) % TD) != 0) cyc_step();
      dv = 8'($urandom_range(0, 31));
      wr(A_DATA, dv, ed); m_dw = dv[4:0]; m_r = ed;
      rd(A_DATA, v); chk("chase_wr_at_step", v, {3'b000, dv[4:0]});
      run_chk(20, "chase_after_wr");
      repeat (2) begin
         rv = 8'($urandom_range(0, 2));
         dv = 8'($urandom_range(0, 31));
         wr(A_RATE, rv, ed); m_rate = int'(rv); m_r = ed;
         wr(A_DATA, dv, ed); m_dw = dv[4:0]; m_r = ed;
         run_chk(30, "chase_rand");
         rd(A_DATA, v); chk("chase_rand_rb", v, {3'b000, m_data(cyc)});
      end

      // PWM (static when the option is not built)
      wr(A_CTRL, 8'h83, ed); m_mode = 3; m_r = ed;
      wr(A_DUTY, 8'h40, ed); m_duty = 64;
      wr(A_DATA, 8'h00, ed); m_dw = 5'h00; m_r = ed;
`ifdef LED_PWM_EN
      rd(A_DUTY, v); chk("duty_rb", v, 8'h40);
`else
      rd(A_DUTY, v); chk("duty_rb", v, 8'h00);
`endif
      lit = 0;
      repeat (256) begin
         cyc_step();
         if (leds == 5'h00) lit++;
      end
`ifdef LED_PWM_EN
      chk("pwm_lit_count", 8'(lit), 8'd64);
`else
      chk("pwm_lit_count", 8'(lit / 2), 8'd128);
`endif
      run_chk(40, "pwm40");
      foreach (dv[i]) begin end
      for (int k = 0; k < 3; k++) begin
         rv = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom_range(1, 254));
         wr(A_DUTY, rv, ed); m_duty = int'(rv);
         run_chk(260, "pwm_duty");
      end

      // Error LED
      wr(A_CTRL, 8'h80, ed); m_mode = 0; m_r = ed;
      wr(A_DATA, 8'h1F, ed); m_dw = 5'h1F; m_r = ed;
      repeat ($urandom_range(1, 7)) cyc_step();
      err_in = 1'b1; cyc_step(); err_in = 1'b0; m_err = 1'b1; m_es = cyc;
      rd(A_STAT, v); chk("err_stat_set", v & 8'h01, 8'h01);
      chk("err_lerr_lat", {7'b0, led_err}, 8'h01);
      run_chk(40, "err_blink");
      bus_wr(A_STAT, 8'h01, 1'b1, 1'b1, ed);
      rd(A_STAT, v); chk("err_set_wins", v & 8'h01, 8'h01);
      run_chk(20, "err_blink2");
      wr(A_STAT, 8'h01, ed); m_err = 1'b0;
      rd(A_STAT, v); chk("err_cleared", v & 8'h01, 8'h00);
      run_chk(1, "err_clr");
      chk("err_off", {7'b0, led_err}, 8'h01);
      run_chk(10, "err_idle");
      repeat ($urandom_range(1, 7)) cyc_step();
      err_in = 1'b1; cyc_step(); err_in = 1'b0; m_err = 1'b1; m_es = cyc;
      run_chk(30, "err_again");
      wr(A_STAT, 8'h01, ed); m_err = 1'b0;
      run_chk(5, "err_clr2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
